keypad_matrix_emulator: RTL

Drives the row lines of the 4x4 matrix keypad bus in response to the column scan, as a closed key contact would. It is the responder end of the keypad scan interface: `keyboard_driver` drives columns and reads rows, and this block answers it. Move sequences are pushed in through a valid/ready handshake. It serves as the stimulus source in the full-system bench and as the injection path for AI moves in `mode_switch` = 1 builds, so both paths exercise the real scanner and debouncer.

---
 rtl/keypad_matrix_emulator_pkg.sv | 34 +++
 rtl/keypad_matrix_emulator_contact.sv | 35 +++
 rtl/keypad_matrix_emulator.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/keypad_matrix_emulator_pkg.sv
// rtl/keypad_matrix_emulator_pkg.sv - shared FSM encoding, key-code layout and sizing helpers
//
// Purpose: constants shared by the keypad emulator top and its contact sub-module.
//   - km_state_t : 2-bit FSM state encoding (IDLE, BOUNCE, HOLD, GAP)
//   - KEY_ROW_*  : row field of the key code, bits [3:2]
//   - KEY_COL_*  : column field of the key code, bits [1:0]
//   - IDLE_LINES : released row/column bus value
// Ports: none (package).
package keypad_matrix_emulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_GAP    = 2'd3
  } km_state_t;

  localparam int KEY_ROW_MSB = 3;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_COL_LSB = 0;

  localparam logic [3:0] IDLE_LINES = 4'hf;

  // Width of the shared phase timer: must hold the largest phase length minus one.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/keypad_matrix_emulator_contact.sv
// rtl/keypad_matrix_emulator_contact.sv - combinational key-contact model between column and row lines
//
// Purpose: models one closed switch of a 4x4 matrix. When the contact is
// closed, the selected row line follows the selected column line; every other
// row floats high. Zero latency, no state.
// Ports:
//   i_contact : 1 = contact closed
//   i_key     : key code {row[1:0], col[1:0]}
//   i_col     : column drive from the scanner, active-low
//   o_row     : row lines to the scanner, active-low, released = 4'hf
module keypad_matrix_emulator_contact
  import keypad_matrix_emulator_pkg::*;
(
  input  logic       i_contact,
  input  logic [3:0] i_key,
  input  logic [3:0] i_col,
  output logic [3:0] o_row
);

  logic [1:0] w_row_sel;
  logic [1:0] w_col_sel;

  assign w_row_sel = i_key[KEY_ROW_MSB:KEY_ROW_LSB];
  assign w_col_sel = i_key[KEY_COL_MSB:KEY_COL_LSB];

  // Only the keyed column is looked at, so several columns driven low at once
  // cannot leak onto the row.
  always_comb begin
    o_row = IDLE_LINES;
    if (i_contact) begin
      o_row[w_row_sel] = i_col[w_col_sel];
    end
  end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// rtl/keypad_matrix_emulator.sv - keypad responder: replays requested key presses onto the matrix row lines
//
// Purpose: accepts one key press per valid/ready handshake and closes the
// matching matrix contact for an optional bounce window plus a solid hold
// time, then keeps it open for a gap before becoming ready again.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   press_valid/ready   : request handshake, ready only in IDLE
//   press_key           : key code {row[1:0], col[1:0]}
//   busy                : high from acceptance until the gap ends
//   done                : one-cycle pulse in the first IDLE cycle after the gap
//   keyboard_col_x4_i   : column drive from the scanner, active-low
//   keyboard_row_x4_o   : row lines to the scanner, active-low, idle 4'hf
module keypad_matrix_emulator
  import keypad_matrix_emulator_pkg::*;
#(
  parameter int HOLD_CYCLES   = 1_000_000,
  parameter int GAP_CYCLES    = 1_000_000,
  parameter int BOUNCE_CYCLES = 0,
  parameter int BOUNCE_PERIOD = 50_000
)(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       press_valid,
  input  logic [3:0] press_key,
  output logic       press_ready,
  output logic       busy,
  output logic       done,
  input  logic [3:0] keyboard_col_x4_i,
  output logic [3:0] keyboard_row_x4_o
);

  localparam int TW = timer_width(HOLD_CYCLES, GAP_CYCLES, BOUNCE_CYCLES);
  localparam int BW = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;

  // Timers count down to zero, so a phase of N cycles loads N-1.
  localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD    = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] BOUNCE_LOAD = TW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [BW-1:0] PERIOD_LOAD = BW'(BOUNCE_PERIOD - 1);

  km_state_t     r_state;
  logic [TW-1:0] r_timer;
  logic [BW-1:0] r_bcnt;
  logic          r_contact;
  logic [3:0]    r_key;
  logic          r_done;

  km_state_t     w_state_next;
  logic [TW-1:0] w_timer_next;
  logic [BW-1:0] w_bcnt_next;
  logic          w_contact_next;
  logic [3:0]    w_key_next;
  logic          w_done_next;
  logic          w_accept;
  logic          w_timer_zero;
  logic          w_bcnt_zero;

  assign w_accept     = press_valid && (r_state == ST_IDLE);
  assign w_timer_zero = (r_timer == '0);
  assign w_bcnt_zero  = (r_bcnt == '0);

  // State register. The contact is registered alongside the state so the row
  // lines change exactly on phase boundaries.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_bcnt    <= '0;
      r_contact <= 1'b0;
      r_key     <= 4'h0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_bcnt    <= w_bcnt_next;
      r_contact <= w_contact_next;
      r_key     <= w_key_next;
      r_done    <= w_done_next;
    end
  end

  // Next-state logic. Every phase entry reloads the shared timer.
  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer;
    w_bcnt_next    = r_bcnt;
    w_contact_next = 1'b0;
    w_key_next     = r_key;
    w_done_next    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_key_next     = press_key;
          w_contact_next = 1'b1;
          if (BOUNCE_CYCLES == 0) begin
            w_state_next = ST_HOLD;
            w_timer_next = HOLD_LOAD;
          end else begin
            w_state_next = ST_BOUNCE;
            w_timer_next = BOUNCE_LOAD;
            w_bcnt_next  = PERIOD_LOAD;
          end
        end
      end
      ST_BOUNCE: begin
        if (w_timer_zero) begin
          w_state_next   = ST_HOLD;
          w_timer_next   = HOLD_LOAD;
          w_contact_next = 1'b1;
        end else begin
          w_timer_next = r_timer - TW'(1);
          // Contact flips each time the period counter expires.
          if (w_bcnt_zero) begin
            w_contact_next = ~r_contact;
            w_bcnt_next    = PERIOD_LOAD;
          end else begin
            w_contact_next = r_contact;
            w_bcnt_next    = r_bcnt - BW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (w_timer_zero) begin
          w_state_next = ST_GAP;
          w_timer_next = GAP_LOAD;
        end else begin
          w_timer_next   = r_timer - TW'(1);
          w_contact_next = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_timer_zero) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    press_ready = (r_state == ST_IDLE);
    busy        = (r_state != ST_IDLE);
    done        = r_done;
  end

  keypad_matrix_emulator_contact u_contact (
    .i_contact (r_contact),
    .i_key     (r_key),
    .i_col     (keyboard_col_x4_i),
    .o_row     (keyboard_row_x4_o)
  );

endmodule
